wb_arbiter: RTL and testbench

Writeback stage directly upstream of the 31-entry register bank. It merges single-cycle ALU results with results from a long-latency unit (loads, multiply) that arrive through a small FIFO. It drives the bank's one-hot write enable and write data, and keeps a per-register busy scoreboard that issue logic uses for hazard stalls.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 46 ++++
 rtl/wb_arbiter.sv | 109 ++++++++++
 tb/tb_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback request type and register one-hot decode
package wb_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;
  function automatic logic [31:1] onehot31(input logic [4:0] rd);
    logic [31:0] t;
    t = 32'd1 << rd;
    return t[31:1];
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t with full/empty/occupancy count
// Ports: clk, reset (async, active-low), push_i/din_i enqueue, pop_i dequeue,
// dout_o head entry, full_o, empty_o, count_o occupancy (0..DEPTH).
// Push while full and pop while empty are ignored.
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  wb_req_t                  din_i,
  input  logic                     pop_i,
  output wb_req_t                  dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wb_req_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;
  always_comb begin
    full_o  = count_q == CW'(DEPTH);
    empty_o = count_q == '0;
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    dout_o  = mem_q[rd_q];
    count_o = count_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback merge of ALU and long-latency results into the register bank
// Ports: clk, reset (async, active-low); alu_valid/alu_rd/alu_data ALU result,
// alu_stall registered hold request; mem_valid/mem_ready/mem_rd/mem_data
// long-latency handshake; issue_valid/issue_rd mark a pending write; busy[31:1]
// scoreboard; addrw[31:1]/wdata registered bank write.
// Macro WB_BYPASS_EN adds rd_addra/rd_addrb/byp_a/byp_b and clears busy one
// cycle earlier (when addrw is registered rather than when the bank captures).
module wb_arbiter import wb_pkg::*; #(
  parameter int MEM_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:1] busy,
  output logic [31:1] addrw,
  output logic [31:0] wdata
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]  rd_addra,
  input  logic [4:0]  rd_addrb,
  output logic        byp_a,
  output logic        byp_b
`endif
);
  localparam int CW = $clog2(MEM_FIFO_DEPTH) + 1;
  wb_req_t        head;
  logic           full, empty, push, alu_win, drain, blocked;
  logic [CW-1:0]  count;
  logic [3:0]     starve_q, starve_d, starve_inc;
  logic           stall_q, stall_d;
  logic [31:1]    addrw_q, addrw_d, busy_q, busy_d, set_m, clr_m;
  logic [31:0]    wdata_q, wdata_d;
`ifndef WB_BYPASS_EN
  logic           mem_wr_q;
`endif
  wb_fifo #(.DEPTH(MEM_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   ('{rd: mem_rd, data: mem_data}),
    .pop_i   (drain),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  always_comb begin
    mem_ready  = count != CW'(MEM_FIFO_DEPTH);
    push       = mem_valid && !full && mem_rd != 5'd0;
    // alu_valid during a stall cycle is a protocol error and is dropped
    alu_win    = alu_valid && alu_rd != 5'd0 && !stall_q;
    drain      = !empty && !alu_win;
    blocked    = !empty && alu_win;
    starve_inc = starve_q + 4'd1;
    stall_d    = blocked && starve_inc == 4'(STARVE_LIMIT);
    starve_d   = blocked && !stall_d ? starve_inc : 4'd0;
    addrw_d    = alu_win ? onehot31(alu_rd) : drain ? onehot31(head.rd) : '0;
    wdata_d    = alu_win ? alu_data : drain ? head.data : wdata_q;
    set_m      = issue_valid ? onehot31(issue_rd) : '0;
`ifdef WB_BYPASS_EN
    clr_m      = drain ? onehot31(head.rd) : '0;
`else
    clr_m      = mem_wr_q ? addrw_q : '0;
`endif
    // a new issue to a register being cleared this edge keeps it busy
    busy_d     = (busy_q & ~clr_m) | set_m;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
      addrw_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
`ifndef WB_BYPASS_EN
      mem_wr_q <= 1'b0;
`endif
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
      addrw_q  <= addrw_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
`ifndef WB_BYPASS_EN
      mem_wr_q <= drain;
`endif
    end
  end
  always_comb begin
    alu_stall = stall_q;
    addrw     = addrw_q;
    wdata     = wdata_q;
    busy      = busy_q;
`ifdef WB_BYPASS_EN
    byp_a     = |(onehot31(rd_addra) & addrw_q);
    byp_b     = |(onehot31(rd_addrb) & addrw_q);
`endif
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter (DEPTH=2, STARVE_LIMIT=4)
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_stall, mem_valid, mem_ready, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd;
  logic [31:0] alu_data, mem_data, wdata;
  logic [31:1] busy, addrw;
`ifdef WB_BYPASS_EN
  logic [4:0]  rd_addra, rd_addrb;
  logic        byp_a, byp_b;
`endif
  typedef struct {
    int          cyc;
    logic [31:1] a;
    logic [31:0] d;
  } exp_t;
  exp_t exp_alu[$];
  exp_t exp_mem[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  wb_arbiter #(.MEM_FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_stall   (alu_stall),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .addrw       (addrw),
    .wdata       (wdata)
`ifdef WB_BYPASS_EN
    ,
    .rd_addra    (rd_addra),
    .rd_addrb    (rd_addrb),
    .byp_a       (byp_a),
    .byp_b       (byp_b)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:1] bit_of(input logic [4:0] r);
    logic [31:1] v;
    v = '0;
    for (int i = 1; i < 32; i++) if (i == int'(r)) v[i] = 1'b1;
    return v;
  endfunction
  task automatic monitor();
    exp_t e;
    if (exp_alu.size() != 0 && exp_alu[0].cyc <= cyc) begin
      e = exp_alu.pop_front();
      n_cmp++;
      if (addrw !== e.a || wdata !== e.d) begin
        n_err++;
        $display("FAIL alu_write cyc=%0d got addrw=%h wdata=%h want addrw=%h wdata=%h", cyc, addrw, wdata, e.a, e.d);
      end
    end else if (addrw !== '0) begin
      n_cmp++;
      if (exp_mem.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write cyc=%0d got addrw=%h wdata=%h want no write", cyc, addrw, wdata);
      end else begin
        e = exp_mem.pop_front();
        if (addrw !== e.a || wdata !== e.d) begin
          n_err++;
          $display("FAIL mem_write cyc=%0d got addrw=%h wdata=%h want addrw=%h wdata=%h", cyc, addrw, wdata, e.a, e.d);
        end
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic clear_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0;
`ifdef WB_BYPASS_EN
    rd_addra = 0; rd_addrb = 0;
`endif
  endtask
  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    exp_alu.delete();
    exp_mem.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask
  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
    if (v && rd != 0) exp_alu.push_back('{cyc + 1, bit_of(rd), d});
  endtask
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #2 reset = 1'b0;
    #1;
    n_cmp += 5;
    if (addrw !== '0) begin n_err++; $display("FAIL rst_addrw got %h want 0", addrw); end
    if (wdata !== '0) begin n_err++; $display("FAIL rst_wdata got %h want 0", wdata); end
    if (busy !== '0) begin n_err++; $display("FAIL rst_busy got %h want 0", busy); end
    if (alu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", alu_stall); end
    if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", mem_ready); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (mem_ready !== 1'b1 || addrw !== '0) begin n_err++; $display("FAIL rst_release got ready=%b addrw=%h want ready=1 addrw=0", mem_ready, addrw); end
  endtask
  task automatic test_alu();
    drive_alu(1, 5'd5, 32'hDEAD_BEEF);
    tick();
    n_cmp += 2;
    if (addrw !== 31'h0000_0010) begin n_err++; $display("FAIL alu_addrw got %h want 00000010", addrw); end
    if (wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alu_wdata got %h want deadbeef", wdata); end
    drive_alu(1, 5'd0, 32'h5555_5555);
    tick();
    n_cmp += 2;
    if (addrw !== '0) begin n_err++; $display("FAIL alu_rd0_addrw got %h want 0", addrw); end
    if (wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alu_rd0_hold got %h want deadbeef", wdata); end
    drive_alu(1, 5'd31, 32'h0BAD_F00D);
    tick();
    drive_alu(1, 5'd1, 32'h0000_0001);
    tick();
    drive_alu(0, 5'd0, 32'h0);
    tick();
    tick();
  endtask
  task automatic sb_run(input bit reissue);
    issue_valid = 1; issue_rd = 5'd7;
    tick();
    issue_valid = 0;
    n_cmp++;
    if (busy[7] !== 1'b1) begin n_err++; $display("FAIL busy_set got %b want 1", busy[7]); end
    tick();
    tick();
    mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h1234;
    exp_mem.push_back('{0, bit_of(5'd7), 32'h1234});
    tick();
    mem_valid = 0;
`ifdef WB_BYPASS_EN
    if (reissue) begin issue_valid = 1; issue_rd = 5'd7; end
    tick();
    issue_valid = 0;
    n_cmp += 2;
    if (addrw !== bit_of(5'd7)) begin n_err++; $display("FAIL drain_write got %h want %h", addrw, bit_of(5'd7)); end
    if (busy[7] !== reissue) begin n_err++; $display("FAIL busy_clear reissue=%0d got %b want %b", reissue, busy[7], reissue); end
`else
    tick();
    n_cmp += 2;
    if (addrw !== bit_of(5'd7)) begin n_err++; $display("FAIL drain_write got %h want %h", addrw, bit_of(5'd7)); end
    if (busy[7] !== 1'b1) begin n_err++; $display("FAIL busy_hold got %b want 1", busy[7]); end
    if (reissue) begin issue_valid = 1; issue_rd = 5'd7; end
    tick();
    issue_valid = 0;
    n_cmp++;
    if (busy[7] !== reissue) begin n_err++; $display("FAIL busy_clear reissue=%0d got %b want %b", reissue, busy[7], reissue); end
`endif
    tick();
  endtask
  task automatic test_scoreboard();
    do_reset();
    sb_run(1'b0);
    sb_run(1'b1);
  endtask
  task automatic test_full_fifo();
    bit st;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      st = (i == 5 || i == 10);
      n_cmp += 2;
      if (alu_stall !== st) begin n_err++; $display("FAIL full_stall i=%0d got %b want %b", i, alu_stall, st); end
      if (mem_ready !== !(i >= 2 && i <= 5)) begin n_err++; $display("FAIL full_ready i=%0d got %b want %b", i, mem_ready, !(i >= 2 && i <= 5)); end
      drive_alu(!st, 5'(10 + i % 4), $urandom);
      mem_valid = i < 3; mem_rd = 5'(20 + i); mem_data = 32'hB000 + i;
      if (i < 2) exp_mem.push_back('{0, bit_of(5'(20 + i)), 32'hB000 + i});
      tick();
    end
    drive_alu(0, 0, 0);
    mem_valid = 0;
    repeat (3) tick();
  endtask
  task automatic test_ordering();
    logic [4:0] rds [5];
    int k;
    rds = '{5'd1, 5'd2, 5'd0, 5'd3, 5'd4};
    k = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (alu_stall !== 1'b0) begin n_err++; $display("FAIL order_stall i=%0d got %b want 0", i, alu_stall); end
      drive_alu(i % 2 == 0 && i < 12, 5'(16 + i / 2), 32'hC000 + i);
      if (k < 5) begin
        mem_valid = 1; mem_rd = rds[k]; mem_data = 32'hA0 + k;
        if (mem_ready) begin
          if (rds[k] != 0) exp_mem.push_back('{0, bit_of(rds[k]), 32'hA0 + k});
          k++;
        end
      end else mem_valid = 0;
      tick();
    end
    mem_valid = 0;
    n_cmp++;
    if (k != 5) begin n_err++; $display("FAIL order_offers got %0d want 5", k); end
    tick();
  endtask
`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    drive_alu(1, 5'd9, 32'h99);
    tick();
    drive_alu(0, 0, 0);
    rd_addra = 5'd9; rd_addrb = 5'd0;
    #1;
    n_cmp += 2;
    if (byp_a !== 1'b1) begin n_err++; $display("FAIL byp_a_hit got %b want 1", byp_a); end
    if (byp_b !== 1'b0) begin n_err++; $display("FAIL byp_b_zero got %b want 0", byp_b); end
    rd_addra = 5'd3; rd_addrb = 5'd9;
    #1;
    n_cmp += 2;
    if (byp_a !== 1'b0) begin n_err++; $display("FAIL byp_a_miss got %b want 0", byp_a); end
    if (byp_b !== 1'b1) begin n_err++; $display("FAIL byp_b_hit got %b want 1", byp_b); end
    tick();
    n_cmp++;
    if (byp_b !== 1'b0) begin n_err++; $display("FAIL byp_idle got %b want 0", byp_b); end
    rd_addra = 0; rd_addrb = 0;
  endtask
`endif
  task automatic test_reset_mid();
    do_reset();
    issue_valid = 1; issue_rd = 5'd1;
    drive_alu(1, 5'd12, 32'h12);
    mem_valid = 1; mem_rd = 5'd1; mem_data = 32'h111;
    tick();
    issue_rd = 5'd2;
    drive_alu(1, 5'd13, 32'h13);
    mem_rd = 5'd2; mem_data = 32'h222;
    tick();
    issue_valid = 0; mem_valid = 0;
    drive_alu(1, 5'd14, 32'h14);
    n_cmp += 2;
    if (mem_ready !== 1'b0) begin n_err++; $display("FAIL mid_full got %b want 0", mem_ready); end
    if (busy !== (bit_of(5'd1) | bit_of(5'd2))) begin n_err++; $display("FAIL mid_busy got %h want %h", busy, bit_of(5'd1) | bit_of(5'd2)); end
    #2 reset = 1'b0;
    #1;
    clear_inputs();
    exp_alu.delete();
    exp_mem.delete();
    n_cmp += 5;
    if (addrw !== '0) begin n_err++; $display("FAIL mid_addrw got %h want 0", addrw); end
    if (wdata !== '0) begin n_err++; $display("FAIL mid_wdata got %h want 0", wdata); end
    if (busy !== '0) begin n_err++; $display("FAIL mid_busy_rst got %h want 0", busy); end
    if (mem_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %b want 1", mem_ready); end
    if (alu_stall !== 1'b0) begin n_err++; $display("FAIL mid_stall got %b want 0", alu_stall); end
    tick();
    reset = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (wdata !== '0) begin n_err++; $display("FAIL mid_no_write got %h want 0", wdata); end
  endtask
  task automatic test_drained();
    n_cmp += 2;
    if (exp_alu.size() != 0) begin n_err++; $display("FAIL alu_pending got %0d want 0", exp_alu.size()); end
    if (exp_mem.size() != 0) begin n_err++; $display("FAIL mem_pending got %0d want 0", exp_mem.size()); end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_scoreboard();
    test_full_fifo();
    test_drained();
    test_ordering();
    test_drained();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    test_drained();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
